// File: rtl/len5_pkg.sv
// Shared widths for the FP datapath of the LEN5 core.
// Pure constants; no logic.
package len5_pkg;
    localparam int unsigned FREG_IDX_LEN = 5;
    localparam int unsigned FLEN         = 64;
endpackage

// File: rtl/fp_rf_wb_buffer.sv
// In-order write-back FIFO between FP commit and the FP register file write port, with 3-port bypass.
// Latency: a result accepted at edge E is on rf_* and visible to bypass in the cycle after E.
// Backpressure: comm_ready_o drops when full (no pass-through); rf_ready_i low holds the head stable.
module fp_rf_wb_buffer
    import len5_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    comm_valid_i,
    output logic                    comm_ready_o,
    input  logic [FREG_IDX_LEN-1:0] comm_rd_idx_i,
    input  logic [FLEN-1:0]         comm_rd_value_i,

    output logic                    rf_valid_o,
    input  logic                    rf_ready_i,
    output logic [FREG_IDX_LEN-1:0] rf_rd_idx_o,
    output logic [FLEN-1:0]         rf_rd_value_o,

    input  logic [FREG_IDX_LEN-1:0] issue_rs1_idx_i,
    output logic                    issue_rs1_hit_o,
    output logic [FLEN-1:0]         issue_rs1_value_o,
    input  logic [FREG_IDX_LEN-1:0] issue_rs2_idx_i,
    output logic                    issue_rs2_hit_o,
    output logic [FLEN-1:0]         issue_rs2_value_o,
    input  logic [FREG_IDX_LEN-1:0] issue_rs3_idx_i,
    output logic                    issue_rs3_hit_o,
    output logic [FLEN-1:0]         issue_rs3_value_o,

    output logic                    empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]           head_q;
    logic [PW-1:0]           tail_q;
    logic [CW-1:0]           count_q;
    logic [FREG_IDX_LEN-1:0] idx_q [DEPTH];
    logic [FLEN-1:0]         val_q [DEPTH];

    logic enq;
    logic deq;

    assign comm_ready_o = (count_q != CW'(DEPTH));
    assign rf_valid_o   = (count_q != '0);
    assign empty_o      = (count_q == '0);

    assign enq = comm_valid_i && comm_ready_o;
    assign deq = rf_valid_o && rf_ready_i;

    // Head is gated by count so stale storage never leaks out when empty.
    assign rf_rd_idx_o   = rf_valid_o ? idx_q[head_q] : '0;
    assign rf_rd_value_o = rf_valid_o ? val_q[head_q] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) tail_q <= tail_q + 1'b1;
            if (deq) head_q <= head_q + 1'b1;
            count_q <= count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            idx_q[tail_q] <= comm_rd_idx_i;
            val_q[tail_q] <= comm_rd_value_i;
        end
    end

    logic [FREG_IDX_LEN-1:0] rs_idx [3];
    logic                    rs_hit [3];
    logic [FLEN-1:0]         rs_val [3];

    assign rs_idx[0] = issue_rs1_idx_i;
    assign rs_idx[1] = issue_rs2_idx_i;
    assign rs_idx[2] = issue_rs3_idx_i;

    // Walk from head (oldest) towards tail so later matches overwrite: youngest wins across wrap.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rs_hit[p] = 1'b0;
            rs_val[p] = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                if ((CW'(i) < count_q) && (idx_q[head_q + PW'(i)] == rs_idx[p])) begin
                    rs_hit[p] = 1'b1;
                    rs_val[p] = val_q[head_q + PW'(i)];
                end
            end
        end
    end

    assign issue_rs1_hit_o   = rs_hit[0];
    assign issue_rs1_value_o = rs_val[0];
    assign issue_rs2_hit_o   = rs_hit[1];
    assign issue_rs2_value_o = rs_val[1];
    assign issue_rs3_hit_o   = rs_hit[2];
    assign issue_rs3_value_o = rs_val[2];

endmodule

// File: tb/tb_fp_rf_wb_buffer.sv
// Directed bench for fp_rf_wb_buffer (DEPTH = 4): inputs driven on the falling edge, outputs checked there too.
module tb_fp_rf_wb_buffer;
    import len5_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    comm_valid;
    logic                    comm_ready;
    logic [FREG_IDX_LEN-1:0] comm_idx;
    logic [FLEN-1:0]         comm_val;
    logic                    rf_valid;
    logic                    rf_ready;
    logic [FREG_IDX_LEN-1:0] rf_idx;
    logic [FLEN-1:0]         rf_val;
    logic [FREG_IDX_LEN-1:0] rs1, rs2, rs3;
    logic                    hit1, hit2, hit3;
    logic [FLEN-1:0]         val1, val2, val3;
    logic                    empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_rf_wb_buffer #(.DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .comm_valid_i(comm_valid), .comm_ready_o(comm_ready),
        .comm_rd_idx_i(comm_idx), .comm_rd_value_i(comm_val),
        .rf_valid_o(rf_valid), .rf_ready_i(rf_ready),
        .rf_rd_idx_o(rf_idx), .rf_rd_value_o(rf_val),
        .issue_rs1_idx_i(rs1), .issue_rs1_hit_o(hit1), .issue_rs1_value_o(val1),
        .issue_rs2_idx_i(rs2), .issue_rs2_hit_o(hit2), .issue_rs2_value_o(val2),
        .issue_rs3_idx_i(rs3), .issue_rs3_hit_o(hit3), .issue_rs3_value_o(val3),
        .empty_o(empty)
    );

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({comm_ready, rf_valid, empty} !== 3'b101) begin
            errors++; $display("FAIL %s_flags got rdy/vld/empty=%b want 101", tag, {comm_ready, rf_valid, empty});
        end
        checks++;
        if (rf_idx !== '0 || rf_val !== '0) begin
            errors++; $display("FAIL %s_head got idx=%0d val=%h want 0/0", tag, rf_idx, rf_val);
        end
        checks++;
        if ({hit1, hit2, hit3} !== 3'b000 || val1 !== '0 || val2 !== '0 || val3 !== '0) begin
            errors++; $display("FAIL %s_bypass got hits=%b v=%h/%h/%h want 000 and zeros", tag, {hit1, hit2, hit3}, val1, val2, val3);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; comm_valid = 1'b0; comm_idx = '0; comm_val = '0; rf_ready = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; rs3 = 5'd0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rf_ready = ~rf_ready;
            @(negedge clk);
            checks++;
            if (rf_valid !== 1'b0 || empty !== 1'b1) begin
                errors++; $display("FAIL idle_c%0d got vld=%b empty=%b want 0/1", c, rf_valid, empty);
            end
        end
    endtask

    task automatic test_single;
        rf_ready = 1'b1; rs2 = 5'd5;
        comm_valid = 1'b1; comm_idx = 5'd5; comm_val = 64'h4000_0000_0000_0000;
        #1;
        checks++;
        if (hit2 !== 1'b0) begin
            errors++; $display("FAIL single_same_cycle got hit=%b want 0", hit2);
        end
        @(negedge clk);
        comm_valid = 1'b0;
        checks++;
        if (rf_valid !== 1'b1 || rf_idx !== 5'd5 || rf_val !== 64'h4000_0000_0000_0000) begin
            errors++; $display("FAIL single_rf got vld=%b idx=%0d val=%h want 1/5/4000000000000000", rf_valid, rf_idx, rf_val);
        end
        checks++;
        if (hit2 !== 1'b1 || val2 !== 64'h4000_0000_0000_0000 || empty !== 1'b0) begin
            errors++; $display("FAIL single_bypass got hit=%b val=%h empty=%b want 1/4000000000000000/0", hit2, val2, empty);
        end
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || hit2 !== 1'b0 || rf_valid !== 1'b0) begin
            errors++; $display("FAIL single_drained got empty=%b hit=%b vld=%b want 1/0/0", empty, hit2, rf_valid);
        end
    endtask

    task automatic test_full;
        rf_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (comm_ready !== 1'b1) begin
                errors++; $display("FAIL full_accept%0d got rdy=%b want 1", k, comm_ready);
            end
            comm_valid = 1'b1; comm_idx = 5'(k); comm_val = 64'h100 + 64'(k);
            @(negedge clk);
        end
        comm_idx = 5'd5; comm_val = 64'h105;
        checks++;
        if (comm_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready got rdy=%b want 0", comm_ready);
        end
        @(negedge clk);
        checks++;
        if (comm_ready !== 1'b0 || rf_idx !== 5'd1 || rf_val !== 64'h101) begin
            errors++; $display("FAIL full_stall got rdy=%b idx=%0d val=%h want 0/1/101", comm_ready, rf_idx, rf_val);
        end
        rf_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            if (k == 2) begin
                checks++;
                if (comm_ready !== 1'b1) begin
                    errors++; $display("FAIL full_freed got rdy=%b want 1", comm_ready);
                end
            end
            if (k == 3) comm_valid = 1'b0;
            checks++;
            if (rf_valid !== 1'b1 || rf_idx !== 5'(k) || rf_val !== 64'h100 + 64'(k)) begin
                errors++; $display("FAIL full_order%0d got vld=%b idx=%0d val=%h want 1/%0d/%h", k, rf_valid, rf_idx, rf_val, k, 64'h100 + 64'(k));
            end
        end
        @(negedge clk);
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL full_empty got %b want 1", empty);
        end
    endtask

    task automatic test_back_to_back;
        rf_ready = 1'b1;
        comm_valid = 1'b1; comm_idx = 5'd10; comm_val = 64'hA000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (rf_valid !== 1'b1 || comm_ready !== 1'b1 || empty !== 1'b0 || rf_val !== 64'hA000 + 64'(k - 1)) begin
                errors++; $display("FAIL b2b_c%0d got vld=%b rdy=%b empty=%b val=%h want 1/1/0/%h", k, rf_valid, comm_ready, empty, rf_val, 64'hA000 + 64'(k - 1));
            end
            comm_idx = 5'(10 + k); comm_val = 64'hA000 + 64'(k);
        end
        @(negedge clk);
        comm_valid = 1'b0;
        checks++;
        if (rf_val !== 64'hA008 || rf_idx !== 5'd18) begin
            errors++; $display("FAIL b2b_last got idx=%0d val=%h want 18/a008", rf_idx, rf_val);
        end
        @(negedge clk);
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL b2b_empty got %b want 1", empty);
        end
    endtask

    task automatic test_wrap_bypass;
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        rf_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            comm_valid = 1'b1; comm_idx = 5'(20 + k); comm_val = 64'(k);
            @(negedge clk);
        end
        comm_valid = 1'b0;
        @(negedge clk);
        rf_ready = 1'b0;
        rs1 = 5'd7; rs2 = 5'd8; rs3 = 5'd9;
        comm_valid = 1'b1; comm_idx = 5'd7; comm_val = 64'hAAAA;
        @(negedge clk);
        comm_val = 64'hBBBB;
        @(negedge clk);
        comm_idx = 5'd9; comm_val = 64'hCCCC;
        #1;
        checks++;
        if (hit3 !== 1'b0) begin
            errors++; $display("FAIL wrap_same_cycle got hit3=%b want 0", hit3);
        end
        @(negedge clk);
        comm_valid = 1'b0;
        checks++;
        if (hit1 !== 1'b1 || val1 !== 64'hBBBB) begin
            errors++; $display("FAIL wrap_rs1 got hit=%b val=%h want 1/bbbb", hit1, val1);
        end
        checks++;
        if (hit3 !== 1'b1 || val3 !== 64'hCCCC) begin
            errors++; $display("FAIL wrap_rs3 got hit=%b val=%h want 1/cccc", hit3, val3);
        end
        checks++;
        if (hit2 !== 1'b0 || val2 !== '0) begin
            errors++; $display("FAIL wrap_rs2 got hit=%b val=%h want 0/0", hit2, val2);
        end
        checks++;
        if (rf_idx !== 5'd7 || rf_val !== 64'hAAAA) begin
            errors++; $display("FAIL wrap_head got idx=%0d val=%h want 7/aaaa", rf_idx, rf_val);
        end
        rf_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rf_idx !== 5'd9 || hit3 !== 1'b1 || val3 !== 64'hCCCC || hit1 !== 1'b0) begin
            errors++; $display("FAIL wrap_head_hit got idx=%0d hit3=%b val3=%h hit1=%b want 9/1/cccc/0", rf_idx, hit3, val3, hit1);
        end
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || hit3 !== 1'b0) begin
            errors++; $display("FAIL wrap_drained got empty=%b hit3=%b want 1/0", empty, hit3);
        end
    endtask

    task automatic test_reset_mid_drain;
        rf_ready = 1'b0;
        rs1 = 5'd3; rs2 = 5'd4; rs3 = 5'd5;
        for (int k = 3; k <= 5; k++) begin
            comm_valid = 1'b1; comm_idx = 5'(k); comm_val = 64'h300 + 64'(k);
            @(negedge clk);
        end
        comm_valid = 1'b0;
        rf_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (rf_valid !== 1'b0 || empty !== 1'b1) begin
                errors++; $display("FAIL midrst_after_c%0d got vld=%b empty=%b want 0/1", c, rf_valid, empty);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_full;
        test_back_to_back;
        test_wrap_bypass;
        test_reset_mid_drain;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_rf_wb_buffer.md
# fp_rf_wb_buffer

Write-back buffer between the commit logic and the floating-point register file write port. It accepts committed FP results via a valid/ready handshake and holds them in an in-order FIFO of `DEPTH` entries. It drains one entry per cycle into the register file whenever the write port is free. It also gives the issue stage a three-port bypass lookup, so operands still waiting in the buffer are read correctly before they reach the register file.

## Interface
- `DEPTH`, default 4: number of buffered results; power of two, ≥ 2.
- `clk_i` input 1: clock, rising-edge.
- `rst_ni` input 1: one clock; reset is asynchronous and active-low.
- `comm_valid_i` input 1: commit logic presents a result.
- `comm_ready_o` output 1: buffer can accept a result this cycle.
- `comm_rd_idx_i` input `len5_pkg::FREG_IDX_LEN`: destination FP register.
- `comm_rd_value_i` input `len5_pkg::FLEN`: result value.
- `rf_valid_o` output 1: write request to the FP register file.
- `rf_ready_i` input 1: register file write port is available this cycle.
- `rf_rd_idx_o` output `FREG_IDX_LEN`: write index, taken from the FIFO head.
- `rf_rd_value_o` output `FLEN`: write data, taken from the FIFO head.
- `issue_rsN_idx_i` (N = 1,2,3) input `FREG_IDX_LEN`: issue-stage operand indices.
- `issue_rsN_hit_o` (N = 1,2,3) output 1: a buffered entry matches `rsN`.
- `issue_rsN_value_o` (N = 1,2,3) output `FLEN`: value of the youngest matching entry; 0 on a miss.
- `empty_o` output 1: no pending entries (used by fences and CSR reads of the FP state).

## Operation
- Circular FIFO with `DEPTH` entries. Each entry holds {idx, value}.
- State:
  - head pointer and tail pointer, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`;
  - `count`, `$clog2(DEPTH)+1` bits.
- Enqueue happens when `comm_valid_i && comm_ready_o`: write the entry at tail, then tail+1.
- Dequeue happens when `rf_valid_o && rf_ready_i`: head+1.
- `comm_ready_o = (count != DEPTH)`.
  - Driven only from registered state.
  - A dequeue in the same cycle does not free a slot while the buffer is full (no pass-through).
- `rf_valid_o = (count != 0)`. `rf_rd_idx_o` and `rf_rd_value_o` are taken combinationally from the head entry.
  - When empty, idx and value are driven to 0.
  - The request is held stable until accepted.
- Simultaneous enqueue and dequeue: `count` is unchanged and both pointers advance.
- Ordering: strictly in order. Duplicate indices are allowed and all of them are written. The last one committed wins in the register file.
- Bypass, per read port:
  - Compare the index against every valid entry, i.e. the entries between head and tail.
  - Select the youngest match, the one closest to tail, so the priority order accounts for wrap-around.
  - The head entry is included even while it is being written this cycle.
  - A result enqueued in the current cycle is not visible until the next cycle.
- Index 0 is an ordinary register (no hard zero in the FP file).
- `empty_o = (count == 0)`.

## Timing
- Reset (asynchronous, any cycle, including mid-drain):
  - `count`, head and tail go to 0 and all pending entries are discarded.
  - `comm_ready_o` = 1, `rf_valid_o` = 0, `rf_rd_idx_o` = 0, `rf_rd_value_o` = 0.
  - All `issue_rsN_hit_o` = 0, all `issue_rsN_value_o` = 0, `empty_o` = 1.
  - Entry storage need not be reset, because the outputs are gated by `count`.
- Latency:
  - A result accepted at edge E appears on `rf_*` in the cycle after E.
  - With `rf_ready_i` = 1 it is written into the register file at edge E+1 and is readable from the register file after E+1.
  - Bypass hits begin in the cycle after E and end once the entry is dequeued.
- Throughput: 1 enqueue and 1 dequeue per cycle.
- `rf_ready_i` low stalls the drain. The head output must not change while it is stalled.
- All outputs depend only on registered state and `issue_rsN_idx_i`. There is no path from `comm_valid_i` or `rf_ready_i` to any output.

## Test plan
- Reset, then idle: all outputs at their reset values. Hold `comm_valid_i` = 0 and toggle `rf_ready_i` for 10 cycles; `rf_valid_o` stays 0 and `empty_o` stays 1.
- Single result: commit idx 5, value 0x4000_0000_0000_0000 with `rf_ready_i` = 1.
  - Next cycle: `rf_valid_o` = 1 with idx 5 and that value, and `issue_rs2_hit_o` = 1 when `rs2` = 5.
  - The cycle after: `empty_o` = 1 and the hit clears.
- Backpressure and full:
  - With `rf_ready_i` = 0, commit 5 results to idx 1..5 (`DEPTH` = 4). Only 4 are accepted; `comm_ready_o` = 0 after the 4th, and the 5th is held.
  - Raise `rf_ready_i`: writes appear in the order 1, 2, 3, 4, one per cycle. The 5th result is accepted in the cycle after the first dequeue.
- Youngest-wins bypass across wrap-around:
  - Advance the pointers by 3 first.
  - With `rf_ready_i` = 0, commit idx 7 with values A then B, then idx 9 with C.
  - Expected: `rs1` = 7 returns B with hit = 1; `rs3` = 9 returns C; `rs2` = 8 gives hit 0 and value 0.
- Simultaneous enqueue and dequeue at count 1 over 8 cycles: `count` stays 1, and the values come out on `rf_*` in commit order with no bubbles.
- Reset mid-drain: with 3 entries pending, assert `rst_ni` low between clock edges. Outputs return to reset values immediately, and no further `rf_valid_o` appears after release.
